// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        HELD,
        DEB_RELEASE
    } btn_state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button lane: 2-flop synchroniser, debounce/long-press FSM and its counters.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 3,
    parameter int LONG_PRESS_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_n_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_press_pulse_o
);

    localparam int            CW        = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_PRESS_CYCLES);
    localparam bit            SINGLE    = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    btn_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          rcnt_q, rcnt_d;
    logic                   pressed_q, pressed_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], button_n_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // cnt counts stable samples seen so far, so acceptance is on the sample that makes it DEBOUNCE_CYCLES.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!s) begin
                    if (SINGLE) begin
                        state_d   = PRESSED;
                        pressed_d = 1'b1;
                        press_d   = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d = DEB_PRESS;
                        cnt_d   = CW'(1);
                    end
                end
            end
            DEB_PRESS: begin
                if (s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = PRESSED;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED, HELD: begin
                if (s) begin
                    if (SINGLE) begin
                        state_d   = IDLE;
                        pressed_d = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        state_d = DEB_RELEASE;
                        rcnt_d  = CW'(1);
                    end
                end else if (state_q == PRESSED) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = HELD;
                        long_d  = 1'b1;
                        cnt_d   = LONG_SAT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DEB_RELEASE: begin
                // The saturated count alone tells us whether the long press already fired.
                if (!s) begin
                    state_d = (cnt_q == LONG_SAT) ? HELD : PRESSED;
                    rcnt_d  = '0;
                end else if (rcnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                    rcnt_d    = '0;
                end else begin
                    rcnt_d = rcnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pressed_o          = pressed_q;
    assign press_pulse_o      = press_q;
    assign release_pulse_o    = release_q;
    assign long_press_pulse_o = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BUTTONS active-low pads into clean levels and one-cycle events.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES   = 3,
    parameter int LONG_PRESS_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] button_n,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_press_pulse
);

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_chan (
            .clk               (clk),
            .rst_n             (rst_n),
            .button_n_i        (button_n[i]),
            .pressed_o         (pressed[i]),
            .press_pulse_o     (press_pulse[i]),
            .release_pulse_o   (release_pulse[i]),
            .long_press_pulse_o(long_press_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model plus directed and random stimulus.
module tb_button_conditioner;

    localparam int NB   = 2;
    localparam int DEB  = 3;
    localparam int LONG = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] button_n;
    logic [NB-1:0] pressed, press_pulse, release_pulse, long_press_pulse;

    button_conditioner #(
        .NUM_BUTTONS      (NB),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .button_n        (button_n),
        .pressed         (pressed),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse)
    );

    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    // Reference: pad delayed by two samples; level flips after DEB consecutive opposite samples;
    // long pulse on the LONG-th sample that is low and follows a low sample while pressed.
    int            m_s1[NB], m_s2[NB], m_prev[NB], m_run[NB], m_long[NB];
    bit            m_fired[NB];
    logic [NB-1:0] exp_pressed, exp_pp, exp_rp, exp_lp;

    task automatic model_reset();
        for (int c = 0; c < NB; c++) begin
            m_s1[c] = 1; m_s2[c] = 1; m_prev[c] = 1;
            m_run[c] = 0; m_long[c] = 0; m_fired[c] = 1'b0;
        end
        exp_pressed = '0; exp_pp = '0; exp_rp = '0; exp_lp = '0;
    endtask

    task automatic model_step();
        for (int c = 0; c < NB; c++) begin
            int s;
            s = m_s2[c];
            exp_pp[c] = 1'b0; exp_rp[c] = 1'b0; exp_lp[c] = 1'b0;
            if (!exp_pressed[c]) begin
                m_run[c] = (s == 0) ? m_run[c] + 1 : 0;
                if (m_run[c] >= DEB) begin
                    exp_pressed[c] = 1'b1; exp_pp[c] = 1'b1;
                    m_run[c] = 0; m_long[c] = 0; m_fired[c] = 1'b0;
                end
            end else begin
                if (s == 0 && m_prev[c] == 0) m_long[c]++;
                if (m_long[c] == LONG && !m_fired[c]) begin
                    exp_lp[c] = 1'b1; m_fired[c] = 1'b1;
                end
                m_run[c] = (s == 1) ? m_run[c] + 1 : 0;
                if (m_run[c] >= DEB) begin
                    exp_pressed[c] = 1'b0; exp_rp[c] = 1'b1; m_run[c] = 0;
                end
            end
            m_prev[c] = s;
            m_s2[c]   = m_s1[c];
            m_s1[c]   = int'(button_n[c]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            nvec++;
            if ({pressed, press_pulse, release_pulse, long_press_pulse} !==
                {exp_pressed, exp_pp, exp_rp, exp_lp}) begin
                nfail++;
                $display("FAIL model t=%0t: pressed/pp/rp/lp got %b/%b/%b/%b required %b/%b/%b/%b",
                         $time, pressed, press_pulse, release_pulse, long_press_pulse,
                         exp_pressed, exp_pp, exp_rp, exp_lp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        button_n = '1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic assert_reset();
        #3 rst_n = 1'b0;
        model_reset();
        #1 lit("reset_outputs_zero",
               int'({pressed, press_pulse, release_pulse, long_press_pulse}), 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int cnt_a, cnt_b, hold[NB];

    initial begin
        rst_n    = 1'b0;
        button_n = '1;
        model_reset();
        repeat (3) @(negedge clk);
        lit("reset_state", int'({pressed, press_pulse, release_pulse, long_press_pulse}), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(4);

        // Clean press on channel 0: low for 5 samples.
        button_n = 2'b10;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 4) lit("clean_pp_e4", int'(press_pulse), 0);
            if (e == 5) begin
                lit("clean_pp_e5", int'(press_pulse), 1);
                lit("clean_pressed_e5", int'(pressed), 1);
            end
        end
        button_n = 2'b11;
        cnt_a = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 4) lit("clean_rp_e4", int'(release_pulse), 0);
            if (e == 5) lit("clean_rp_e5", int'(release_pulse), 1);
            cnt_a += int'(long_press_pulse[0]) + int'(pressed[1]);
        end
        lit("clean_no_long_no_ch1", cnt_a, 0);

        // Glitch on channel 1.
        button_n = 2'b01;
        cnt_a = 0;
        tick(); tick();
        button_n = 2'b11;
        for (int e = 0; e < 10; e++) begin
            tick();
            cnt_a += int'(pressed[1]) + int'(press_pulse[1]) + int'(release_pulse[1]);
        end
        lit("glitch_ch1_silent", cnt_a, 0);

        // Long press on channel 0.
        button_n = 2'b10;
        cnt_a = 0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 5)  lit("long_pp_e5", int'(press_pulse[0]), 1);
            if (e == 20) lit("long_lp_e20", int'(long_press_pulse[0]), 0);
            if (e == 21) lit("long_lp_e21", int'(long_press_pulse[0]), 1);
            cnt_a += int'(long_press_pulse[0]);
        end
        lit("long_once", cnt_a, 1);
        button_n = 2'b11;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 5) lit("long_rp_e5", int'(release_pulse[0]), 1);
        end

        // Release bounce while held.
        button_n = 2'b10;
        for (int e = 0; e < 10; e++) tick();
        cnt_a = 0; cnt_b = 0;
        button_n = 2'b11; tick(); tick();
        button_n = 2'b10;
        for (int e = 0; e < 12; e++) begin
            tick();
            cnt_a += int'(press_pulse[0]) + int'(release_pulse[0]);
            cnt_b += int'(pressed[0]);
        end
        lit("bounce_no_pulses", cnt_a, 0);
        lit("bounce_stays_pressed", cnt_b, 12);
        idle(8);

        // Both buttons on the same edge.
        button_n = 2'b00;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (e == 5) lit("simul_pp", int'(press_pulse), 3);
        end
        idle(10);

        // Reset while channel 0 is pressed, pad still low.
        button_n = 2'b10;
        for (int e = 0; e < 8; e++) tick();
        lit("pre_reset_pressed", int'(pressed[0]), 1);
        cnt_a = 0;
        assert_reset();
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 4) lit("rst_pp_e4", int'(press_pulse[0]), 0);
            if (e == 5) lit("rst_pp_e5", int'(press_pulse[0]), 1);
            cnt_a += int'(release_pulse[0]);
        end
        lit("rst_no_release", cnt_a, 0);
        idle(8);

        // Random pads with bounce and hold periods, one reset in the middle.
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    button_n[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 40));
                end
                hold[c]--;
            end
            if (i == 1500) assert_reset();
            tick();
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
